cnt121_down: RTL and testbench
==============================

Name: cnt121_down

Overview:
- Loadable down counter over the same 0..120 range and digit encoding as the team's mod-121 up counter, so the two can share displays and comparators.
- Counts down from a loaded or reset value and reports a one-cycle borrow when it wraps from 0 back to the top value.
- Acts as a countdown/timeout source that pairs with the up counter (e.g. a remaining-time display driven from the same digit bus).
- Optional one-shot mode stops at zero instead of wrapping.

Parameters:
- TOP_H, 12, tens digit of the top/reset value (binary 0..12).
- TOP_L, 0, ones digit of the top/reset value (0..9); TOP_H*10+TOP_L must be at most 120.
- ONE_SHOT, 0, 0 = wrap 0->top with borrow; 1 = hold at 0 and assert Done.

Ports:
- Clk  in  1  clock, all state changes on the rising edge.
- MR  in  1  reset, synchronous, active-high.
- En  in  1  count enable; decrement by 1 per enabled cycle.
- Load  in  1  synchronous load request of DH:DL.
- DH  in  4  load tens digit, binary 0..12.
- DL  in  4  load ones digit, 0..9.
- QH  out  4  current tens digit, 0..12.
- QL  out  4  current ones digit, 0..9.
- B  out  1  registered borrow pulse, one cycle.
- Z  out  1  combinational zero flag, (QH==0 && QL==0).
- Done  out  1  registered; ONE_SHOT=1 only, high while halted at 0; tied 0 when ONE_SHOT=0.
- LdErr  out  1  registered one-cycle pulse on a rejected load.

Behaviour:
- Reset: MR sampled high at a rising edge sets the following. MR overrides every other input.
  - QH=TOP_H, QL=TOP_L.
  - B=0, Done=0, LdErr=0.
- Priority per edge: MR > Load > En.
- Load, valid when DL<=9 and DH<=12 and (DH<12 or DL==0):
  - QH:QL <= DH:DL.
  - B=0, LdErr=0.
  - Done cleared, then re-evaluated: Done=1 next cycle only if the loaded value is 0 and ONE_SHOT=1.
  - No decrement occurs that cycle even if En=1.
- Load, invalid:
  - QH:QL unchanged and no decrement that cycle.
  - LdErr=1 for exactly one cycle.
  - B=0.
- En=1, Load=0, count nonzero:
  - If QL>0: QL<=QL-1.
  - Else: QL<=9 and QH<=QH-1.
  - Latency 1 cycle.
- En=1, Load=0, count==0:
  - ONE_SHOT=0: QH:QL <= TOP_H:TOP_L, and B=1 in the cycle the top value first appears.
  - ONE_SHOT=1: count holds at 0, Done=1 (stays high until a Load or MR), B stays 0.
- En=0: count holds; B=0; LdErr=0.
- B and LdErr are never high two consecutive cycles unless the triggering event repeats.
- Z follows QH:QL combinationally, with no added latency.
- Digit invariants: QL never exceeds 9; QH never exceeds 12; QH=12 implies QL=0. These hold even if TOP is misconfigured, and the bench asserts them every cycle.
- Full period with ONE_SHOT=0 and En held high: 121 cycles between B pulses.

Test Plan:
- Reset: MR=1 for 3 cycles with En=1 and Load=1 -> QH=12, QL=0, B=0, LdErr=0, Z=0 after each edge. Release MR -> next edge QH=11, QL=9.
- Free run: from reset, En=1 for 121 cycles.
  - Sequence follows 120,119,...,110,109,...,1,0,120.
  - Z=1 only when 0 is shown.
  - B=1 exactly in the cycle 120 reappears.
  - Second B arrives 121 cycles later.
- Ones-to-tens borrow: Load DH=5, DL=0, then En=1 -> next values 49, 48. The value 4:10 never appears.
- Load rules:
  - DH=7, DL=3 with En=1 -> 73, no decrement that cycle; LdErr=0.
  - DH=12, DL=5 -> count unchanged, LdErr=1 for one cycle.
  - DL=10 -> count unchanged, LdErr=1.
- One-shot (ONE_SHOT=1): Load 0:2, En=1 -> 1, 0, then holds 0.
  - Done=1 from the cycle after 0 is reached; B never asserts.
  - Load 0:5 -> Done=0 and counting resumes.
- Reset mid-operation: at count 37 with En=1, assert MR for one cycle with Load=1 and DH:DL=9:9 -> 120. LdErr=0, B=0; next enabled edge gives 119.

Source files
------------

// File: rtl/cnt121_down.sv
// Loadable mod-121 down counter on a tens/ones digit pair (0..120).
// Wraps 0 -> top with a one-cycle borrow, or halts at 0 in one-shot mode.
module cnt121_down #(
  parameter int unsigned TOP_H    = 12,
  parameter int unsigned TOP_L    = 0,
  parameter int unsigned ONE_SHOT = 0
) (
  input  logic       Clk,
  input  logic       MR,
  input  logic       En,
  input  logic       Load,
  input  logic [3:0] DH,
  input  logic [3:0] DL,
  output logic [3:0] QH,
  output logic [3:0] QL,
  output logic       B,
  output logic       Z,
  output logic       Done,
  output logic       LdErr
);

  // A top value outside the digit encoding falls back to 12:0 so the digit invariants always hold.
  localparam bit TOP_OK = (TOP_L <= 32'd9) && (TOP_H <= 32'd12) &&
                          ((TOP_H < 32'd12) || (TOP_L == 32'd0));
  localparam logic [3:0] TOP_H_C = TOP_OK ? 4'(TOP_H) : 4'd12;
  localparam logic [3:0] TOP_L_C = TOP_OK ? 4'(TOP_L) : 4'd0;
  localparam bit         OS      = (ONE_SHOT != 32'd0);

  logic [3:0] qh_q, qh_d, ql_q, ql_d;
  logic       b_q, b_d, done_q, done_d, lderr_q, lderr_d;
  logic       load_ok_s, zero_s;

  assign load_ok_s = (DL <= 4'd9) && (DH <= 4'd12) && ((DH < 4'd12) || (DL == 4'd0));
  assign zero_s    = (qh_q == 4'd0) && (ql_q == 4'd0);

  // Next-state selection: Load beats En; pulses default low every cycle.
  always_comb begin
    qh_d    = qh_q;
    ql_d    = ql_q;
    b_d     = 1'b0;
    lderr_d = 1'b0;
    done_d  = done_q;
    if (Load) begin
      if (load_ok_s) begin
        qh_d   = DH;
        ql_d   = DL;
        done_d = OS && (DH == 4'd0) && (DL == 4'd0);
      end else begin
        lderr_d = 1'b1;
      end
    end else if (En) begin
      if (!zero_s) begin
        if (ql_q != 4'd0) begin
          ql_d = ql_q - 4'd1;
        end else begin
          ql_d = 4'd9;
          qh_d = qh_q - 4'd1;
        end
      end else if (!OS) begin
        qh_d = TOP_H_C;
        ql_d = TOP_L_C;
        b_d  = 1'b1;
      end else begin
        done_d = 1'b1;
      end
    end else begin
      qh_d = qh_q;
      ql_d = ql_q;
    end
  end

  // State and registered flags; MR overrides everything.
  always_ff @(posedge Clk) begin
    if (MR) begin
      qh_q    <= TOP_H_C;
      ql_q    <= TOP_L_C;
      b_q     <= 1'b0;
      done_q  <= 1'b0;
      lderr_q <= 1'b0;
    end else begin
      qh_q    <= qh_d;
      ql_q    <= ql_d;
      b_q     <= b_d;
      done_q  <= done_d;
      lderr_q <= lderr_d;
    end
  end

  assign QH    = qh_q;
  assign QL    = ql_q;
  assign B     = b_q;
  assign Z     = zero_s;
  assign Done  = done_q;
  assign LdErr = lderr_q;

endmodule

// File: tb/tb_cnt121_down.sv
// Bench for cnt121_down: wrapping and one-shot instances share stimulus and are
// compared every cycle against an integer-valued reference model.
module tb_cnt121_down;

  logic       Clk = 1'b0;
  logic       MR = 1'b0, En = 1'b0, Load = 1'b0;
  logic [3:0] DH = 4'd0, DL = 4'd0;
  logic [3:0] qh [2];
  logic [3:0] ql [2];
  logic       b [2], z [2], done [2], lderr [2];

  int n_cmp = 0, n_bad = 0, cyc = 0, last_b = -1;
  bit per_chk = 1'b0;
  int m_v [2];
  bit m_b [2], m_d [2], m_e [2];

  always #5 Clk = ~Clk;

  cnt121_down #(.TOP_H(12), .TOP_L(0), .ONE_SHOT(0)) u_wrap (
    .Clk(Clk), .MR(MR), .En(En), .Load(Load), .DH(DH), .DL(DL),
    .QH(qh[0]), .QL(ql[0]), .B(b[0]), .Z(z[0]), .Done(done[0]), .LdErr(lderr[0]));

  cnt121_down #(.TOP_H(12), .TOP_L(0), .ONE_SHOT(1)) u_os (
    .Clk(Clk), .MR(MR), .En(En), .Load(Load), .DH(DH), .DL(DL),
    .QH(qh[1]), .QL(ql[1]), .B(b[1]), .Z(z[1]), .Done(done[1]), .LdErr(lderr[1]));

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Reference: count is a plain integer 0..120, digits derived by /10 and %10.
  task automatic model(input int m, input bit mr, ld, en, input int dh, dl);
    bit ok;
    ok = (dl <= 9) && (dh <= 12) && (dh * 10 + dl <= 120);
    if (mr) begin
      m_v[m] = 120; m_b[m] = 0; m_d[m] = 0; m_e[m] = 0;
    end else if (ld) begin
      m_b[m] = 0;
      if (ok) begin
        m_v[m] = dh * 10 + dl; m_e[m] = 0; m_d[m] = (m == 1) && (m_v[m] == 0);
      end else begin
        m_e[m] = 1;
      end
    end else begin
      m_b[m] = 0; m_e[m] = 0;
      if (en) begin
        if (m_v[m] > 0) m_v[m] = m_v[m] - 1;
        else if (m == 0) begin m_v[m] = 120; m_b[m] = 1; end
        else m_d[m] = 1;
      end
    end
  endtask

  task automatic step(input bit mr, ld, en, input int dh, dl);
    MR = mr; Load = ld; En = en; DH = 4'(dh); DL = 4'(dl);
    @(posedge Clk);
    for (int m = 0; m < 2; m++) model(m, mr, ld, en, dh, dl);
    #1;
    cyc++;
    for (int m = 0; m < 2; m++) begin
      check(m == 0 ? "QH_wrap" : "QH_os", int'(qh[m]), m_v[m] / 10);
      check(m == 0 ? "QL_wrap" : "QL_os", int'(ql[m]), m_v[m] % 10);
      check(m == 0 ? "B_wrap" : "B_os", int'(b[m]), int'(m_b[m]));
      check(m == 0 ? "Z_wrap" : "Z_os", int'(z[m]), int'(m_v[m] == 0));
      check(m == 0 ? "Done_wrap" : "Done_os", int'(done[m]), int'(m_d[m]));
      check(m == 0 ? "LdErr_wrap" : "LdErr_os", int'(lderr[m]), int'(m_e[m]));
      check("digit_inv", int'((ql[m] <= 4'd9) && (qh[m] <= 4'd12) &&
                              ((qh[m] != 4'd12) || (ql[m] == 4'd0))), 1);
    end
    if (per_chk && b[0] === 1'b1) begin
      if (last_b >= 0) check("B_period", cyc - last_b, 121);
      last_b = cyc;
    end
  endtask

  initial begin
    int val;
    bit mr, ld, en;
    int dh, dl;
    for (int m = 0; m < 2; m++) begin
      m_v[m] = 120; m_b[m] = 0; m_d[m] = 0; m_e[m] = 0;
    end
    // Reset dominates Load and En
    for (int i = 0; i < 3; i++) step(1, 1, 1, 9, 9);
    // Free run across two wraps, period of borrow checked
    per_chk = 1'b1;
    for (int i = 0; i < 245; i++) step(0, 0, 1, 0, 0);
    per_chk = 1'b0;
    // Ones-to-tens borrow
    step(0, 1, 0, 5, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    // Load rules: valid load wins over En, invalid loads flagged
    step(0, 1, 1, 7, 3);
    step(0, 1, 1, 12, 5);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 3, 10);
    step(0, 1, 1, 15, 0);
    step(0, 1, 0, 12, 0);
    step(0, 0, 1, 0, 0);
    // One-shot halt, then reload resumes
    step(0, 1, 0, 0, 2);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 5);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Reset mid-operation
    step(0, 1, 0, 3, 7);
    step(1, 1, 1, 9, 9);
    step(0, 0, 1, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      mr = ($urandom_range(0, 99) < 2);
      ld = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) begin
        val = $urandom_range(0, 120);
        dh = val / 10; dl = val % 10;
      end else begin
        dh = $urandom_range(0, 15); dl = $urandom_range(0, 15);
      end
      step(mr, ld, en, dh, dl);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
